// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: stores {header-marker, byte}
// entries and presents one registered byte per read to the destination port.
module router_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W   = ADDR_WIDTH + 1;
    localparam int ENTRY_W = DATA_WIDTH + 1;
    localparam int PKT_W   = 7;

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PKT_W-1:0]      pkt_count_q, pkt_count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic                  full_w;
    logic                  empty_w;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [ENTRY_W-1:0]    rd_entry;

    // The MSB of each pointer is a wrap bit, so equal low bits mean empty or full.
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    assign wr_fire  = write_enb && !full_w && !soft_reset;
    assign rd_fire  = read_enb && !empty_w && !soft_reset;
    assign rd_entry = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_count_d = pkt_count_q;
        data_out_d  = data_out_q;
        if (soft_reset) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_count_d = '0;
            data_out_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                data_out_d = rd_entry[DATA_WIDTH-1:0];
                // A header carries the payload length in its upper bits; +1 counts parity.
                if (rd_entry[DATA_WIDTH]) begin
                    pkt_count_d = PKT_W'(rd_entry[DATA_WIDTH-1:2]) + PKT_W'(1);
                end else if (pkt_count_q != '0) begin
                    pkt_count_d = pkt_count_q - PKT_W'(1);
                end
            end else if (pkt_count_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            data_out_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            data_out_q  <= data_out_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_fire) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out = data_out_q;
    assign full     = full_w;
    assign empty    = empty_w;

endmodule

// File: tb/tb_router_fifo.sv
// Directed, table-driven bench for router_fifo: each record is one clock of
// inputs plus the outputs expected just after that edge.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       srst;
        logic       we;
        logic       re;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       full;
        logic       empty;
        int         grp;
    } vec_t;

    vec_t vq[$];

    router_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    function automatic void add(input logic rst, input logic srst, input logic we,
                                input logic re, input logic lfd, input logic [7:0] din,
                                input logic [7:0] dout, input logic f, input logic e,
                                input int grp);
        vec_t v;
        v.rst = rst; v.srst = srst; v.we = we; v.re = re; v.lfd = lfd;
        v.din = din; v.dout = dout; v.full = f; v.empty = e; v.grp = grp;
        vq.push_back(v);
    endfunction

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic srst, input logic we, input logic re,
                        input logic lfd, input logic [7:0] din);
        @(negedge clock);
        reset = rst; soft_reset = srst; write_enb = we; read_enb = re;
        lfd_state = lfd; data_in = din;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] dout,
                         input logic f, input logic e);
        n_vec++;
        if (data_out !== dout || full !== f || empty !== e) begin
            n_err++;
            $display("FAIL %s[%0d]: got data_out=%02h full=%0b empty=%0b, want data_out=%02h full=%0b empty=%0b",
                     name, idx, data_out, full, empty, dout, f, e);
        end
    endtask

    initial begin
        // 1: reset, then a read on an empty FIFO
        add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 1);
        add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 1);
        add(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 1);
        add(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 1);

        // 2: header 0D (length 3), three payload bytes, parity 5C
        add(0, 0, 1, 0, 1, 8'h0D, 8'h00, 0, 0, 2);
        add(0, 0, 1, 0, 0, 8'hA1, 8'h00, 0, 0, 2);
        add(0, 0, 1, 0, 0, 8'hA2, 8'h00, 0, 0, 2);
        add(0, 0, 1, 0, 0, 8'hA3, 8'h00, 0, 0, 2);
        add(0, 0, 1, 0, 0, 8'h5C, 8'h00, 0, 0, 2);
        add(0, 0, 0, 1, 0, 8'h00, 8'h0D, 0, 0, 2);
        add(0, 0, 0, 1, 0, 8'h00, 8'hA1, 0, 0, 2);
        add(0, 0, 0, 1, 0, 8'h00, 8'hA2, 0, 0, 2);
        add(0, 0, 0, 1, 0, 8'h00, 8'hA3, 0, 0, 2);
        add(0, 0, 0, 1, 0, 8'h00, 8'h5C, 0, 1, 2);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 2);

        // 3: fill with 00..0F, drop a 17th write, drain in order
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 0, 0, 8'(i), 8'h00, (i == 15), 0, 3);
        add(0, 0, 1, 0, 0, 8'hFF, 8'h00, 1, 0, 3);
        for (int i = 0; i < 16; i++)
            add(0, 0, 0, 1, 0, 8'h00, 8'(i), 0, (i == 15), 3);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 3);

        // 4: refill, then write+read while full; EE must never come out
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 0, 0, 8'(i), 8'h00, (i == 15), 0, 4);
        add(0, 0, 1, 1, 0, 8'hEE, 8'h00, 0, 0, 4);
        for (int i = 1; i < 16; i++)
            add(0, 0, 0, 1, 0, 8'h00, 8'(i), 0, (i == 15), 4);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 4);

        // 5: shift pointers by 10, then fill/drain 20..2F across the wrap
        for (int i = 0; i < 10; i++)
            add(0, 0, 1, 0, 0, 8'h30 + 8'(i), 8'h00, 0, 0, 5);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 1, 0, 8'h00, 8'h30 + 8'(i), 0, (i == 9), 5);
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 0, 0, 8'h20 + 8'(i), 8'h00, (i == 15), 0, 5);
        // write+read with neither flag set keeps occupancy (after one read it is 15)
        add(0, 0, 0, 1, 0, 8'h00, 8'h20, 0, 0, 5);
        add(0, 0, 1, 1, 0, 8'h40, 8'h21, 0, 0, 5);
        for (int i = 2; i < 16; i++)
            add(0, 0, 0, 1, 0, 8'h00, 8'h20 + 8'(i), 0, 0, 5);
        add(0, 0, 0, 1, 0, 8'h00, 8'h40, 0, 1, 5);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 5);
        // write+read while empty: only the write happens
        add(0, 0, 1, 1, 0, 8'h55, 8'h00, 0, 0, 5);
        add(0, 0, 0, 1, 0, 8'h00, 8'h55, 0, 1, 5);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 5);

        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].srst, vq[i].we, vq[i].re, vq[i].lfd, vq[i].din);
            check($sformatf("grp%0d", vq[i].grp), i, vq[i].dout, vq[i].full, vq[i].empty);
        end

        // 6: soft_reset in the middle of a packet, then a fresh packet
        step(0, 0, 1, 0, 1, 8'h10);
        check("srst_wr", 0, 8'h00, 0, 0);
        step(0, 0, 1, 0, 0, 8'hB1);
        step(0, 0, 1, 0, 0, 8'hB2);
        step(0, 0, 0, 1, 0, 8'h00);
        check("srst_hdr", 0, 8'h10, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00);
        check("srst_hold", 0, 8'h10, 0, 0);
        step(0, 1, 1, 1, 0, 8'h99);
        check("srst_flush", 0, 8'h00, 0, 1);
        step(0, 0, 0, 1, 0, 8'h00);
        check("srst_after", 0, 8'h00, 0, 1);
        step(0, 0, 1, 0, 1, 8'h04);
        step(0, 0, 1, 0, 0, 8'hC1);
        step(0, 0, 1, 0, 0, 8'hC2);
        check("new_pkt_wr", 0, 8'h00, 0, 0);
        step(0, 0, 0, 1, 0, 8'h00);
        check("new_pkt", 0, 8'h04, 0, 0);
        step(0, 0, 0, 1, 0, 8'h00);
        check("new_pkt", 1, 8'hC1, 0, 0);
        step(0, 0, 0, 1, 0, 8'h00);
        check("new_pkt", 2, 8'hC2, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00);
        check("new_pkt_idle", 0, 8'h00, 0, 1);

        // reset mid-contents clears everything
        step(0, 0, 1, 0, 0, 8'h77);
        step(1, 0, 0, 0, 0, 8'h00);
        check("hard_reset", 0, 8'h00, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
